// File: rtl/keypad_pin_entry.sv
// 4x4 active-low keypad scanner with press/release debounce, key decode and an
// N-digit BCD entry buffer (digit shift-in, backspace, enter, overflow, clear).
module keypad_pin_entry #(
   parameter int N_DIGITS     = 4,
   parameter int SCAN_DIV     = 50000,
   parameter int DEBOUNCE_CYC = 200000
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [3:0]                    column,
   output logic [3:0]                    row,
   input  logic                          clear,
   output logic [3:0]                    key_code,
   output logic                          key_strobe,
   output logic [4*N_DIGITS-1:0]         entry_digits,
   output logic [$clog2(N_DIGITS+1)-1:0] entry_count,
   output logic                          entry_valid,
   output logic                          overflow
);
   localparam int CNT_MAX = (SCAN_DIV > DEBOUNCE_CYC) ? SCAN_DIV : DEBOUNCE_CYC;
   localparam int CW      = $clog2(CNT_MAX + 1);
   localparam int NW      = $clog2(N_DIGITS + 1);
   localparam int DW      = 4 * N_DIGITS;
   localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_DIV - 1);
   localparam logic [CW-1:0] DEB_LAST  = CW'(DEBOUNCE_CYC - 1);
   localparam logic [NW-1:0] FULL      = NW'(N_DIGITS);

   typedef enum logic [1:0] {SCAN, DEBOUNCE, PRESSED} state_t;

   state_t        state;
   logic [3:0]    col_s1, col_s2;
   logic [1:0]    row_idx, col_idx;
   logic [CW-1:0] cnt;

   function automatic logic [1:0] low_col(input logic [3:0] c);
      if (!c[0])      return 2'd0;
      else if (!c[1]) return 2'd1;
      else if (!c[2]) return 2'd2;
      else            return 2'd3;
   endfunction

   // Column 3 is A-D, row 3 is *,0,#; the remaining 3x3 block is 1-9.
   function automatic logic [3:0] decode(input logic [1:0] r, input logic [1:0] c);
      if (c == 2'd3)      return 4'hA + {2'b00, r};
      else if (r == 2'd3) return (c == 2'd0) ? 4'hE : (c == 2'd1) ? 4'h0 : 4'hF;
      else                return ({2'b00, r} * 4'd3) + {2'b00, c} + 4'd1;
   endfunction

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         col_s1     <= 4'hF;
         col_s2     <= 4'hF;
         state      <= SCAN;
         row_idx    <= 2'd0;
         row        <= 4'b1110;
         col_idx    <= 2'd0;
         cnt        <= '0;
         key_code   <= 4'h0;
         key_strobe <= 1'b0;
      end else begin
         col_s1     <= column;
         col_s2     <= col_s1;
         key_strobe <= 1'b0;
         unique case (state)
            SCAN: begin
               if (cnt == SCAN_LAST) begin
                  cnt <= '0;
                  if (col_s2 != 4'hF) begin
                     col_idx <= low_col(col_s2);
                     state   <= DEBOUNCE;
                  end else begin
                     row_idx <= row_idx + 2'd1;
                     row     <= {row[2:0], row[3]};
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            DEBOUNCE: begin
               if (col_s2[col_idx]) begin
                  state   <= SCAN;
                  cnt     <= '0;
                  row_idx <= row_idx + 2'd1;
                  row     <= {row[2:0], row[3]};
               end else if (cnt == DEB_LAST) begin
                  state      <= PRESSED;
                  cnt        <= '0;
                  key_strobe <= 1'b1;
                  key_code   <= decode(row_idx, col_idx);
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            PRESSED: begin
               // Release needs an unbroken run of all-high columns.
               if (col_s2 != 4'hF) begin
                  cnt <= '0;
               end else if (cnt == DEB_LAST) begin
                  state   <= SCAN;
                  cnt     <= '0;
                  row_idx <= row_idx + 2'd1;
                  row     <= {row[2:0], row[3]};
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: state <= SCAN;
         endcase
      end
   end

   // Enter leaves the buffer visible for the entry_valid cycle, then empties it.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         entry_digits <= '0;
         entry_count  <= '0;
         entry_valid  <= 1'b0;
         overflow     <= 1'b0;
      end else begin
         entry_valid <= 1'b0;
         overflow    <= 1'b0;
         if (clear || entry_valid) begin
            entry_digits <= '0;
            entry_count  <= '0;
         end else if (key_strobe) begin
            if (key_code <= 4'h9) begin
               if (entry_count == FULL) begin
                  overflow <= 1'b1;
               end else begin
                  entry_digits <= (entry_digits << 4) | DW'(key_code);
                  entry_count  <= entry_count + 1'b1;
               end
            end else if (key_code == 4'hE) begin
               if (entry_count != '0) begin
                  entry_digits <= entry_digits >> 4;
                  entry_count  <= entry_count - 1'b1;
               end
            end else if (key_code == 4'hF) begin
               entry_valid <= 1'b1;
            end
         end
      end
   end
endmodule

// File: tb/tb_keypad_pin_entry.sv
// Bench for keypad_pin_entry: keypad matrix model, queue-based buffer model
// checked every cycle, and directed key sequences with literal expectations.
module tb_keypad_pin_entry;
   localparam int N   = 4;
   localparam int SD  = 4;
   localparam int DEB = 8;

   logic             clk = 1'b0, rst = 1'b0, clear = 1'b0;
   logic [3:0]       column, row, key_code;
   logic             key_strobe, entry_valid, overflow;
   logic [4*N-1:0]   entry_digits;
   logic [2:0]       entry_count;
   logic [3:0][3:0]  keys = '0;

   keypad_pin_entry #(.N_DIGITS(N), .SCAN_DIV(SD), .DEBOUNCE_CYC(DEB)) dut (
      .clk(clk), .rst(rst), .column(column), .row(row), .clear(clear),
      .key_code(key_code), .key_strobe(key_strobe), .entry_digits(entry_digits),
      .entry_count(entry_count), .entry_valid(entry_valid), .overflow(overflow)
   );

   always #5 clk = ~clk;

   // A held key shorts its column low while its row is driven low.
   always_comb begin
      column = 4'hF;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            if (keys[r][c] && !row[r]) column[c] = 1'b0;
   end

   int n_checks = 0, n_pass = 0;
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
   endtask

   int keymap [4][4] = '{'{1, 2, 3, 10}, '{4, 5, 6, 11}, '{7, 8, 9, 12}, '{14, 0, 15, 13}};

   int          m_buf[$];
   int          exp_q[$];
   bit          m_valid = 0, m_ovf = 0;
   int          m_last = 0;
   int          n_strobe = 0, n_valid = 0, n_ovf = 0;
   logic [31:0] v_digits = 0, v_count = 0;

   function automatic logic [31:0] buf_val();
      logic [31:0] v;
      v = 0;
      foreach (m_buf[i]) v = (v << 4) | m_buf[i];
      return v;
   endfunction

   always begin
      @(negedge clk);
      #2;
      if (!rst) begin
         m_buf.delete();
         m_valid = 0;
         m_ovf   = 0;
         m_last  = 0;
         chk("rst_row", row, 4'b1110);
         chk("rst_digits", entry_digits, 0);
         chk("rst_count", entry_count, 0);
         chk("rst_valid", entry_valid, 0);
         chk("rst_overflow", overflow, 0);
         chk("rst_strobe", key_strobe, 0);
         chk("rst_key_code", key_code, 0);
      end else begin
         bit nv, no;
         int code;
         nv = 0; no = 0; code = -1;
         chk("row_one_low", ($countones(~row) == 1), 1);
         chk("entry_digits", entry_digits, buf_val());
         chk("entry_count", entry_count, m_buf.size());
         chk("entry_valid", entry_valid, m_valid);
         chk("overflow", overflow, m_ovf);
         if (entry_valid) begin
            n_valid++;
            v_digits = entry_digits;
            v_count  = entry_count;
         end
         if (overflow) n_ovf++;
         if (key_strobe) begin
            n_strobe++;
            if (exp_q.size() == 0) chk("unexpected_strobe_queue", exp_q.size(), 1);
            else begin
               code = exp_q.pop_front();
               chk("key_code_strobe", key_code, code);
               m_last = code;
            end
         end else begin
            chk("key_code_hold", key_code, m_last);
         end
         if (clear || m_valid) m_buf.delete();
         else if (code >= 0 && code <= 9) begin
            if (m_buf.size() < N) m_buf.push_back(code);
            else no = 1;
         end else if (code == 14) begin
            if (m_buf.size() > 0) void'(m_buf.pop_back());
         end else if (code == 15) nv = 1;
         m_valid = nv;
         m_ovf   = no;
      end
   end

   task automatic press(input int r, input int c, input int hold);
      int lat;
      exp_q.push_back(keymap[r][c]);
      @(posedge clk);
      #1 keys[r][c] = 1'b1;
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!key_strobe && lat < 100);
      chk("strobe_latency_max", (lat <= 4*SD + DEB + 4), 1);
      chk("strobe_latency_min", (lat >= DEB + 2), 1);
      repeat (hold) @(posedge clk);
      #1 keys[r][c] = 1'b0;
      repeat (30) @(posedge clk);
   endtask

   initial begin
      logic [3:0] er;
      int         k, s0;

      // Idle scan after reset: 4 cycles per row.
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      for (int i = 0; i <= 16; i++) begin
         @(negedge clk);
         er = ~(4'b0001 << ((i / 4) % 4));
         chk("scan_row", row, er);
      end

      // Bounce: key held through reset is released 4 cycles into debounce.
      @(posedge clk);
      #1 rst = 1'b0; keys[0][0] = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      repeat (6) @(posedge clk);
      #1 keys[0][0] = 1'b0;
      repeat (3) @(posedge clk);
      #1 keys[0][0] = 1'b1;
      repeat (5) @(posedge clk);
      #1 keys[0][0] = 1'b0;
      repeat (40) @(posedge clk);
      chk("bounce_no_strobe", n_strobe, 0);

      press(0, 0, 20); press(0, 1, 20); press(0, 2, 20); press(1, 0, 20);
      chk("digits_1234", entry_digits, 16'h1234);
      chk("count_4", entry_count, 4);

      press(1, 1, 20);
      chk("overflow_once", n_ovf, 1);
      chk("digits_kept_1234", entry_digits, 16'h1234);

      press(3, 0, 20);
      chk("bksp_digits", entry_digits, 16'h0123);
      chk("bksp_count", entry_count, 3);

      press(3, 2, 20);
      chk("enter_pulses", n_valid, 1);
      chk("enter_digits", v_digits, 16'h0123);
      chk("enter_count", v_count, 3);
      chk("after_enter_digits", entry_digits, 0);
      chk("after_enter_count", entry_count, 0);

      press(3, 0, 20);
      chk("bksp_empty_code", key_code, 4'hE);
      chk("bksp_empty_count", entry_count, 0);
      press(1, 3, 20);
      chk("key_b_code", key_code, 4'hB);
      chk("key_b_digits", entry_digits, 0);

      s0 = n_strobe;
      press(2, 0, 1000);
      chk("held_one_strobe", n_strobe - s0, 1);
      chk("held_digits", entry_digits, 16'h0007);

      // clear in the strobe cycle of a digit that would overflow
      press(0, 0, 20); press(0, 1, 20); press(0, 2, 20);
      chk("full_digits", entry_digits, 16'h7123);
      exp_q.push_back(7);
      @(posedge clk);
      #1 keys[2][0] = 1'b1;
      k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (!key_strobe && k < 100);
      chk("clr_strobe_seen", key_strobe, 1);
      clear = 1'b1;
      @(posedge clk);
      #1 clear = 1'b0;
      repeat (20) @(posedge clk);
      #1 keys[2][0] = 1'b0;
      repeat (30) @(posedge clk);
      chk("clr_digits", entry_digits, 0);
      chk("clr_count", entry_count, 0);
      chk("clr_no_overflow", n_ovf, 1);

      press(2, 2, 20);
      chk("nine_digits", entry_digits, 16'h0009);
      @(posedge clk);
      #1 clear = 1'b1;
      @(posedge clk);
      #1 clear = 1'b0;
      @(negedge clk);
      chk("plain_clear", entry_digits, 0);

      // Reset mid-debounce of key 5, then re-detection from row 0.
      press(2, 1, 20);
      chk("eight_digits", entry_digits, 16'h0008);
      exp_q.push_back(5);
      s0 = n_strobe;
      for (int i = 0; i < 100 && row != 4'b1110; i++) @(negedge clk);
      for (int i = 0; i < 100 && row != 4'b1101; i++) @(negedge clk);
      keys[1][1] = 1'b1;
      repeat (8) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("mid_rst_row", row, 4'b1110);
      chk("mid_rst_digits", entry_digits, 0);
      chk("mid_rst_key_code", key_code, 0);
      chk("mid_rst_no_strobe", n_strobe - s0, 0);
      @(posedge clk);
      #1 rst = 1'b1;
      for (k = 0; k < 200; k++) begin
         @(negedge clk);
         if (key_strobe) break;
      end
      chk("redetect_latency", k, 16);
      repeat (20) @(posedge clk);
      #1 keys[1][1] = 1'b0;
      repeat (30) @(posedge clk);
      chk("redetect_digits", entry_digits, 16'h0005);
      chk("redetect_count", entry_count, 1);
      chk("all_keys_strobed", exp_q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", n_pass, n_checks);
      $fatal(1);
   end
endmodule

// File: doc/keypad_pin_entry.md
# keypad_pin_entry

Parametrised successor to the fixed 4-digit keypad path. Scans a 4x4 active-low matrix keypad, debounces presses internally on the selected row, decodes each press to a 4-bit key code, and accumulates an N-digit entry buffer with backspace and enter editing. The buffer and count feed the LCD controller's data path, and a one-cycle enter strobe feeds the password checker.

## Interface
- N_DIGITS, 4, entry buffer depth in digits (1..8)
- SCAN_DIV, 50000, clk cycles each row is driven before its columns are sampled
- DEBOUNCE_CYC, 200000, consecutive stable cycles required for press and for release
- clk  in  1  system clock
- rst  in  1  reset; one clock, reset is asynchronous and active-low
- column  in  4  keypad columns, active-low (pulled up), asynchronous
- row  out  4  keypad row drive, active-low, exactly one row low at all times
- clear  in  1  synchronous buffer clear, active-high
- key_code  out  4  code of the last accepted key
- key_strobe  out  1  one-cycle pulse per accepted key
- entry_digits  out  4*N_DIGITS  BCD buffer, newest digit in [3:0]
- entry_count  out  $clog2(N_DIGITS+1)  digits held
- entry_valid  out  1  one-cycle pulse on enter
- overflow  out  1  one-cycle pulse when a digit is rejected because the buffer is full

## Operation
- Keymap (row r, col c): r0 = 1,2,3,A; r1 = 4,5,6,B; r2 = 7,8,9,C; r3 = *,0,#,D. Codes: digits 0x0-0x9, A-D 0xA-0xD, * 0xE (backspace), # 0xF (enter).
- column passes through a 2-flop synchroniser before any use.
- Scanner FSM:
  - SCAN: drive row_idx low for SCAN_DIV cycles. At the last cycle of the slot, if any synced column is low, latch row_idx and the lowest-index low column, clear the counter, and go to DEBOUNCE. Otherwise advance row_idx modulo 4 and stay in SCAN.
  - DEBOUNCE: row held. The latched column must stay low for DEBOUNCE_CYC consecutive cycles, then go to PRESSED. If it goes high, return to SCAN at the next row.
  - PRESSED: on entry, assert key_strobe for 1 cycle with key_code valid. Wait until all synced columns are high for DEBOUNCE_CYC consecutive cycles (counter restarts on any low), then return to SCAN at the next row.
- A held key generates exactly one strobe. No auto-repeat.
- Buffer update is applied on the cycle after key_strobe:
  - Digit, count < N_DIGITS: shift buffer left 4 bits, insert the digit at [3:0], count+1.
  - Digit, count == N_DIGITS: buffer unchanged, overflow pulses 1 cycle.
  - Backspace: shift right 4 bits (zero fill at the top), count-1. No-op at count 0.
  - Enter: entry_valid pulses 1 cycle with entry_digits and entry_count unchanged. On the next cycle, buffer and count clear to 0. Enter at count 0 still pulses entry_valid.
  - A-D: strobe only, buffer unchanged.
- clear: buffer and count go to 0 on the next edge. If clear coincides with a buffer update, clear wins and the update is discarded, including any entry_valid or overflow pulse. clear does not affect the scanner.

## Timing
- Reset values: row = 4'b1110 (row_idx 0), state SCAN, all counters 0, key_code 0, key_strobe 0, entry_digits 0, entry_count 0, entry_valid 0, overflow 0.
- Reset mid-press: the scanner restarts at row 0 in SCAN. A still-held key is re-detected and strobed again after the full debounce time.
- Press latency: column edge, then 2 sync cycles, then up to 4*SCAN_DIV cycles to reach the row slot, then DEBOUNCE_CYC cycles, then +1 cycle to key_strobe.
- Buffer outputs change 1 cycle after key_strobe. entry_valid and overflow are asserted in that same cycle.
- After release, a new press is detected no sooner than DEBOUNCE_CYC + 1 cycles.
- Counters must be sized to hold max(SCAN_DIV, DEBOUNCE_CYC).

## Test plan
- Reset, no keys → row cycles 1110, 1101, 1011, 0111, dwelling SCAN_DIV cycles per row; all outputs 0; no strobe.
- Press 1, 2, 3, 4 (r0c0, r0c1, r0c2, r1c0) with SCAN_DIV=4, DEBOUNCE_CYC=8 → four strobes; entry_digits=0x1234, entry_count=4.
- From 0x1234, press 5 → overflow pulses once; buffer stays 0x1234. Press * → 0x0123, count 3. Press # → entry_valid with 0x0123/3, then 0x0000/0 on the next cycle.
- Key bouncing (low for 5 cycles, high, low again) with DEBOUNCE_CYC=8 → no strobe. Key held for 1000 cycles → exactly one strobe.
- Backspace at count 0 → strobe 0xE, buffer unchanged. Key B → strobe 0xB, buffer unchanged.
- clear asserted in the same cycle the buffer would apply digit 7 → buffer 0, count 0, no overflow. rst pulsed mid-DEBOUNCE → outputs return to reset values, row=1110.
